// File: rtl/segre_icache_refill_if.sv
// Memory read bus between the icache refill unit (master) and the memory
// port (slave): request/grant for the line address, then rvalid data beats.
interface segre_icache_refill_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_BYTES  = 4
);
  // Handshake: the master raises mem_req_o with mem_addr_o and holds both
  // stable until it samples mem_gnt_i high on a rising edge; the request is
  // then consumed. Each later cycle with mem_rvalid_i high carries one beat
  // on mem_rdata_i, and there is no backpressure on beats.
  logic                   mem_req_o;
  logic [ADDR_WIDTH-1:0]  mem_addr_o;
  logic                   mem_gnt_i;
  logic                   mem_rvalid_i;
  logic [BUS_BYTES*8-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/segre_icache_refill.sv
// Instruction-cache miss handler: fetches a line over the memory bus and
// writes it into a round-robin victim lane. Optional performance counters
// are enabled with the macro SEGRE_ICACHE_REFILL_PERF_EN.
module segre_icache_refill #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter int BUS_BYTES  = 4,
  parameter int NUM_LANES  = 4,
  parameter int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int TAG_W      = ADDR_WIDTH - $clog2(LINE_BYTES)
) (
  input  logic                    clk_i,
  input  logic                    rsn_i,
  input  logic                    miss_i,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr_i,
  input  logic                    invalidate_i,
  segre_icache_refill_if.master   mem,
  output logic                    refill_we_o,
  output logic [LANE_W-1:0]       refill_index_o,
  output logic [TAG_W-1:0]        refill_tag_o,
  output logic [LINE_BYTES*8-1:0] refill_line_o,
  output logic                    busy_o,
  output logic [1:0]              dbg_state_o
`ifdef SEGRE_ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0]             perf_miss_cnt_o,
  output logic [31:0]             perf_stall_cnt_o
`endif
);

  localparam int BUS_W  = BUS_BYTES * 8;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int BEATS  = LINE_BYTES / BUS_BYTES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(NUM_LANES - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(LINE_BYTES - 1));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t                r_state;
  logic [BEAT_W-1:0]     r_beat;
  logic [LANE_W-1:0]     r_victim;
  logic                  r_abort;
  logic [LINE_W-1:0]     r_line;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_W-1:0]     w_line_next;

  // Line buffer with the current beat merged in, so the final beat can be
  // presented on refill_line_o in the same edge that enters WRITE.
  always_comb begin
    w_line_next = r_line;
    w_line_next[r_beat*BUS_W +: BUS_W] = mem.mem_rdata_i;
  end

  assign mem.mem_addr_o = r_addr & LINE_MASK;
  assign busy_o         = (r_state != ST_IDLE);
  assign dbg_state_o    = r_state;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state        <= ST_IDLE;
      r_beat         <= '0;
      r_victim       <= '0;
      r_abort        <= 1'b0;
      r_line         <= '0;
      r_addr         <= '0;
      mem.mem_req_o  <= 1'b0;
      refill_we_o    <= 1'b0;
      refill_index_o <= '0;
      refill_tag_o   <= '0;
      refill_line_o  <= '0;
    end else begin
      refill_we_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (invalidate_i) r_victim <= '0;
          if (miss_i) begin
            r_addr        <= fetch_addr_i;
            r_beat        <= '0;
            mem.mem_req_o <= 1'b1;
            r_state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (invalidate_i) r_abort <= 1'b1;
          if (mem.mem_gnt_i) begin
            mem.mem_req_o <= 1'b0;
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (invalidate_i) r_abort <= 1'b1;
          if (mem.mem_rvalid_i) begin
            r_line <= w_line_next;
            r_beat <= r_beat + 1'b1;
            if (r_beat == LAST_BEAT) begin
              // A flush seen on the last beat still cancels the write.
              if (r_abort || invalidate_i) begin
                r_abort <= 1'b0;
                r_state <= ST_IDLE;
              end else begin
                refill_we_o    <= 1'b1;
                refill_index_o <= r_victim;
                refill_tag_o   <= r_addr[ADDR_WIDTH-1 -: TAG_W];
                refill_line_o  <= w_line_next;
                r_state        <= ST_WRITE;
              end
            end
          end
        end
        ST_WRITE: begin
          r_victim <= (r_victim == LAST_LANE) ? '0 : r_victim + 1'b1;
          r_abort  <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SEGRE_ICACHE_REFILL_PERF_EN
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      perf_miss_cnt_o  <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (r_state == ST_IDLE && miss_i && perf_miss_cnt_o != 32'hFFFF_FFFF)
        perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
      if (busy_o && perf_stall_cnt_o != 32'hFFFF_FFFF)
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_segre_icache_refill.sv
// Directed testbench for segre_icache_refill: scenario tasks drive the miss
// and memory bus and compare outputs against hand-derived expectations.
module tb_segre_icache_refill;

  localparam int BEATS = 4;

  logic         clk;
  logic         rsn_i;
  logic         miss_i;
  logic [31:0]  fetch_addr_i;
  logic         invalidate_i;
  logic         refill_we_o;
  logic [1:0]   refill_index_o;
  logic [27:0]  refill_tag_o;
  logic [127:0] refill_line_o;
  logic         busy_o;
  logic [1:0]   dbg_state_o;
`ifdef SEGRE_ICACHE_REFILL_PERF_EN
  logic [31:0]  perf_miss_cnt_o;
  logic [31:0]  perf_stall_cnt_o;
`endif

  int vectors;
  int miscompares;

  segre_icache_refill_if #(.ADDR_WIDTH(32), .BUS_BYTES(4)) mem_if ();

  segre_icache_refill dut (
    .clk_i          (clk),
    .rsn_i          (rsn_i),
    .miss_i         (miss_i),
    .fetch_addr_i   (fetch_addr_i),
    .invalidate_i   (invalidate_i),
    .mem            (mem_if.master),
    .refill_we_o    (refill_we_o),
    .refill_index_o (refill_index_o),
    .refill_tag_o   (refill_tag_o),
    .refill_line_o  (refill_line_o),
    .busy_o         (busy_o),
    .dbg_state_o    (dbg_state_o)
`ifdef SEGRE_ICACHE_REFILL_PERF_EN
    ,
    .perf_miss_cnt_o  (perf_miss_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    miss_i              = 1'b0;
    fetch_addr_i        = 32'h0;
    invalidate_i        = 1'b0;
    mem_if.mem_gnt_i    = 1'b0;
    mem_if.mem_rvalid_i = 1'b0;
    mem_if.mem_rdata_i  = 32'h0;
  endtask

  // One refill. Cycle 1 is the first cycle after the edge that samples the
  // miss. Beats carry base+k; optional gap after beat gap_after, invalidate
  // pulse in the cycle after beat inv_after, and a stress mode holding
  // miss_i high and driving stray rvalid during REQ.
  task automatic run_refill(input string name, input logic [31:0] addr,
                            input logic [31:0] base, input int gnt_dly,
                            input int gap_after, input int inv_after,
                            input bit inv_first, input bit stress,
                            input logic [1:0] exp_idx, input bit exp_write);
    logic [31:0]  exp_addr;
    logic [27:0]  exp_tag;
    logic [127:0] exp_line;
    int  cyc, beat, end_cyc, last_cyc, we_cnt, we_cyc, req_rise;
    bit  gap_now, inv_next, prev_req, bad_req, bad_busy;
    exp_addr = addr & 32'hFFFF_FFF0;
    exp_tag  = addr[31:4];
    for (int k = 0; k < BEATS; k++) exp_line[k*32 +: 32] = base + 32'(k);
    end_cyc  = 2 + gnt_dly + BEATS + ((gap_after >= 0) ? 1 : 0);
    last_cyc = exp_write ? end_cyc + 1 : end_cyc;
    cyc = 0; beat = 0; we_cnt = 0; we_cyc = -1; req_rise = 0;
    gap_now = 0; inv_next = 0; prev_req = 0; bad_req = 0; bad_busy = 0;
    miss_i       = 1'b1;
    fetch_addr_i = addr;
    invalidate_i = inv_first;
    while (cyc < last_cyc) begin
      @(posedge clk); #1;
      cyc++;
      miss_i              = stress && (cyc < end_cyc);
      invalidate_i        = inv_next;
      inv_next            = 0;
      mem_if.mem_gnt_i    = (cyc == 1 + gnt_dly);
      mem_if.mem_rvalid_i = 1'b0;
      mem_if.mem_rdata_i  = 32'h0;
      if (stress && cyc <= 1 + gnt_dly) begin
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = 32'hDEAD_BEEF;
      end
      if (cyc >= 2 + gnt_dly && beat < BEATS) begin
        if (gap_now) gap_now = 0;
        else begin
          mem_if.mem_rvalid_i = 1'b1;
          mem_if.mem_rdata_i  = base + 32'(beat);
          if (beat == gap_after) gap_now = 1;
          if (beat == inv_after) inv_next = 1;
          beat++;
        end
      end
      if (mem_if.mem_req_o && !prev_req) req_rise++;
      prev_req = mem_if.mem_req_o;
      if (mem_if.mem_req_o !== (cyc <= 1 + gnt_dly)) bad_req = 1;
      if (cyc <= 1 + gnt_dly && mem_if.mem_addr_o !== exp_addr) bad_req = 1;
      if (cyc < last_cyc && busy_o !== 1'b1) bad_busy = 1;
      if (refill_we_o === 1'b1) begin
        we_cnt++;
        we_cyc = cyc;
        vectors++;
        if (refill_index_o !== exp_idx) begin
          miscompares++;
          $display("FAIL %s index: got %0d want %0d", name, refill_index_o, exp_idx);
        end
        vectors++;
        if (refill_tag_o !== exp_tag) begin
          miscompares++;
          $display("FAIL %s tag: got %h want %h", name, refill_tag_o, exp_tag);
        end
        vectors++;
        if (refill_line_o !== exp_line) begin
          miscompares++;
          $display("FAIL %s line: got %h want %h", name, refill_line_o, exp_line);
        end
      end
    end
    vectors++;
    if (bad_req) begin
      miscompares++;
      $display("FAIL %s req/addr: addr now %h want %h while requesting", name,
               mem_if.mem_addr_o, exp_addr);
    end
    vectors++;
    if (req_rise != 1) begin
      miscompares++;
      $display("FAIL %s req_count: got %0d want 1", name, req_rise);
    end
    vectors++;
    if (bad_busy || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy: final %b want 0, dropped early %b", name, busy_o, bad_busy);
    end
    vectors++;
    if (we_cnt != (exp_write ? 1 : 0) || (exp_write && we_cyc != end_cyc)) begin
      miscompares++;
      $display("FAIL %s we: got %0d pulses at cycle %0d want %0d at cycle %0d", name,
               we_cnt, we_cyc, exp_write ? 1 : 0, exp_write ? end_cyc : -1);
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rsn_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({mem_if.mem_req_o, mem_if.mem_addr_o, refill_we_o, refill_index_o,
         busy_o, dbg_state_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctl: req %b addr %h we %b idx %0d busy %b st %0d",
               mem_if.mem_req_o, mem_if.mem_addr_o, refill_we_o, refill_index_o,
               busy_o, dbg_state_o);
    end
    vectors++;
    if (refill_tag_o !== 28'h0 || refill_line_o !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_data: tag %h line %h want 0", refill_tag_o, refill_line_o);
    end
    rsn_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_refill("basic", 32'h0000_1234, 32'h0000_00A0, 0, -1, -1, 0, 0, 2'd0, 1);
    @(posedge clk); #1;
    vectors++;
    if (refill_line_o !== 128'h000000A3_000000A2_000000A1_000000A0 ||
        refill_tag_o !== 28'h0000123 || refill_we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_hold: line %h tag %h we %b", refill_line_o, refill_tag_o,
               refill_we_o);
    end
  endtask

  // First refill also raises invalidate with the miss: pointer back to 0
  // and the refill is not aborted.
  task automatic test_wrap();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++)
      run_refill("wrap", 32'h0002_0000 + 32'(i * 16), 32'h0B00_0000 + 32'(i * 256),
                 0, -1, -1, (i == 0), 0, exp_seq[i], 1);
  endtask

  task automatic test_delay();
    run_refill("delay", 32'h8000_0FFC, 32'h1000_0000, 3, 1, -1, 0, 0, 2'd1, 1);
  endtask

  task automatic test_miss_hold();
    mem_if.mem_rvalid_i = 1'b1;
    mem_if.mem_rdata_i  = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    run_refill("miss_hold", 32'h0000_7770, 32'h0C00_0000, 2, -1, -1, 0, 1, 2'd2, 1);
  endtask

  task automatic test_abort();
    run_refill("abort", 32'h0000_4440, 32'h0D00_0000, 0, -1, 1, 0, 0, 2'd3, 0);
    run_refill("after_abort", 32'h0000_4450, 32'h0E00_0000, 1, -1, -1, 0, 0, 2'd3, 1);
  endtask

  task automatic test_reset_mid();
    run_refill("pre_reset", 32'h0000_3330, 32'h0F00_0000, 0, -1, -1, 0, 0, 2'd0, 1);
    miss_i       = 1'b1;
    fetch_addr_i = 32'h0000_BEEC;
    @(posedge clk); #1;
    miss_i           = 1'b0;
    mem_if.mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_if.mem_gnt_i    = 1'b0;
    mem_if.mem_rvalid_i = 1'b1;
    mem_if.mem_rdata_i  = 32'h1111_1111;
    @(posedge clk); #1;
    mem_if.mem_rdata_i  = 32'h2222_2222;
    @(posedge clk); #1;
    mem_if.mem_rvalid_i = 1'b0;
    #2;
    rsn_i = 1'b0;
    #1;
    vectors++;
    if ({mem_if.mem_req_o, mem_if.mem_addr_o, refill_we_o, refill_index_o,
         busy_o, dbg_state_o} !== '0) begin
      miscompares++;
      $display("FAIL async_reset_ctl: addr %h busy %b st %0d", mem_if.mem_addr_o,
               busy_o, dbg_state_o);
    end
    vectors++;
    if (refill_tag_o !== 28'h0 || refill_line_o !== 128'h0) begin
      miscompares++;
      $display("FAIL async_reset_data: tag %h line %h want 0", refill_tag_o,
               refill_line_o);
    end
    clear_inputs();
    @(posedge clk); #1;
    rsn_i = 1'b1;
    @(posedge clk); #1;
    run_refill("post_reset", 32'h0000_0040, 32'h0A0A_0000, 0, -1, -1, 0, 0, 2'd0, 1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_delay();
    test_miss_hold();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/segre_icache_refill.md
Name: segre_icache_refill

Overview:
- Instruction-cache miss handler. Sits directly downstream of the icache tag array's miss output and upstream of its tag-update port.
- On a tag miss it fetches the full line from memory over a request/grant + rvalid bus and assembles the beats.
- It then writes the line into the victim lane chosen by a round-robin pointer and issues the one-cycle tag update strobe (valid set, tag written) to the tag array.
- Stalls fetch while a refill is in flight.

Parameters:
- ADDR_WIDTH, 32, fetch/memory byte address width
- LINE_BYTES, 16, cache line size in bytes (power of 2)
- BUS_BYTES, 4, memory data bus width in bytes; BEATS = LINE_BYTES/BUS_BYTES (power of 2, >=1)
- NUM_LANES, 4, number of cache lanes (fully associative); LANE_W = $clog2(NUM_LANES)
- TAG_W, derived: ADDR_WIDTH - $clog2(LINE_BYTES)

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  asynchronous active-low reset
- miss_i  in  1  tag-array miss for the current fetch
- fetch_addr_i  in  ADDR_WIDTH  address of the missing fetch
- invalidate_i  in  1  flush of all icache lanes
- mem_req_o  out  1  line read request
- mem_addr_o  out  ADDR_WIDTH  line-aligned request address (low $clog2(LINE_BYTES) bits zero)
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read beat valid
- mem_rdata_i  in  BUS_BYTES*8  read beat data
- refill_we_o  out  1  one-cycle tag/data write strobe (drives the tag array's mmu_data input)
- refill_index_o  out  LANE_W  victim lane
- refill_tag_o  out  TAG_W  fetch_addr[ADDR_WIDTH-1 -: TAG_W]
- refill_line_o  out  LINE_BYTES*8  assembled line
- busy_o  out  1  refill in progress (fetch stall)

Behaviour:
- Reset (rsn_i low, asynchronous): state IDLE, beat counter 0, victim pointer 0, abort flag 0, line buffer 0, latched address 0. All outputs 0.
- FSM states:
  - IDLE: on miss_i=1, latch fetch_addr_i, clear beat counter, go to REQ. miss_i=0: stay.
  - REQ: mem_req_o=1, mem_addr_o = latched address line-aligned, held stable until mem_gnt_i. On gnt go to WAIT. mem_rvalid_i is ignored in REQ.
  - WAIT: each mem_rvalid_i=1 stores mem_rdata_i at line bits [k*BUS_BYTES*8 +: BUS_BYTES*8], where k = beat counter, then increments the counter. On the beat with k=BEATS-1 go to WRITE, or to IDLE if the abort flag is set.
  - WRITE: refill_we_o=1 for exactly this cycle, with refill_index_o = victim pointer, refill_tag_o, and refill_line_o valid. Victim pointer increments mod NUM_LANES (wraps 3->0). Next state IDLE.
- busy_o = (state != IDLE); combinational from registered state.
- Latency, best case (gnt in first REQ cycle, back-to-back beats): miss sampled at edge 0 -> mem_req_o cycle 1 -> beats cycles 2..1+BEATS -> refill_we_o cycle 2+BEATS (cycle 6 for defaults). IDLE in cycle 3+BEATS; a new miss is accepted that cycle.
- miss_i while busy_o=1: ignored, not queued.
- Unsolicited mem_rvalid_i in IDLE or REQ: ignored.
- Gaps between beats are allowed; the counter only advances on rvalid.
- invalidate_i:
  - In IDLE: victim pointer reset to 0.
  - In REQ or WAIT: set the abort flag. The bus transaction still completes (request held until gnt, all BEATS beats drained), then return to IDLE with no refill_we_o. Abort flag clears on entry to IDLE.
  - In WRITE: the write still occurs. The tag array's invalidate takes priority in that same cycle.
- miss_i and invalidate_i both high in IDLE: invalidate acts and the miss is accepted; the refill is not aborted.
- refill_line_o and refill_tag_o hold their last values outside WRITE; only refill_we_o qualifies them.

Optional Feature:
- Macro: SEGRE_ICACHE_REFILL_PERF_EN
- When defined, adds outputs:
  - perf_miss_cnt_o (32 bits): increments on every accepted miss.
  - perf_stall_cnt_o (32 bits): increments every cycle busy_o=1.
- Both counters saturate at 0xFFFFFFFF and reset to 0; invalidate does not clear them.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then miss_i=1 with fetch_addr_i=0x0000_1234, gnt immediate, beats 0xA0,0xA1,0xA2,0xA3 back-to-back -> mem_addr_o=0x0000_1230; refill_we_o in cycle 6 only, refill_index_o=0, refill_tag_o=0x0000123, refill_line_o=0x000000A3_000000A2_000000A1_000000A0.
- Five consecutive refills -> refill_index_o sequence 0,1,2,3,0 (pointer wrap).
- gnt delayed 3 cycles plus one idle cycle between beats 1 and 2 -> mem_req_o/mem_addr_o stable through the delay; refill_we_o at cycle 10; busy_o high cycles 1..9 and in the write cycle 10, low from cycle 11.
- invalidate_i pulse during WAIT after beat 1 -> remaining beats drained, no refill_we_o, back to IDLE; the next refill uses the victim lane that would have been used.
- miss_i held high during a refill plus stray mem_rvalid_i in IDLE -> exactly one mem_req_o per IDLE->REQ entry; stray data never appears in refill_line_o.
- rsn_i asserted mid-WAIT -> outputs 0 immediately (asynchronously); the victim pointer restarts at 0 on the next refill.
